// File: rtl/fifo_wptr_full_ctrl_if.sv
// Write-side bundle of the async FIFO: producer request, synchronised read
// pointer, and the pointer/flag outputs of the write controller.
interface fifo_wptr_full_ctrl_if #(
  parameter int N = 4
);
  logic         winc;
  logic [N:0]   wq2_rptr;
  logic         wen;
  logic [N-1:0] waddr;
  logic [N:0]   wbin;
  logic         wfull;
  logic         walmost_full;
  logic [N:0]   wcount;
  logic         wovf;

  // master: the write-domain environment (producer + read-pointer synchroniser)
  modport master (
    output winc, wq2_rptr,
    input  wen, waddr, wbin, wfull, walmost_full, wcount, wovf
  );

  modport slave (
    input  winc, wq2_rptr,
    output wen, waddr, wbin, wfull, walmost_full, wcount, wovf
  );
endinterface

// File: rtl/fifo_wptr_full_ctrl.sv
// Async FIFO write-pointer and full-flag controller (write clock domain).
// Flags describe the state after this cycle's write, so there is no extra latency.
module fifo_wptr_full_ctrl #(
  parameter int N         = 4,
  parameter int AF_THRESH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_wptr_full_ctrl_if.slave   wif
);

  localparam logic [N:0] DEPTH    = (N+1)'(2**N);
  localparam logic [N:0] AF_LEVEL = (N+1)'(AF_THRESH);

  logic [N:0] rbin;
  logic [N:0] wbin_next;
  logic [N:0] fill_next;
  logic [N:0] wbin_q;
  logic [N:0] wcount_q;
  logic       wfull_q;
  logic       walmost_full_q;
  logic       wovf_q;
  logic       wen_c;

  // Gray to binary: each binary bit is the parity of the Gray bits at and above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= N; i++) begin
      rbin[i] = ^(wif.wq2_rptr >> i);
    end
  end

  always_comb begin
    wen_c     = wif.winc & ~wfull_q & ~rst;
    wbin_next = wbin_q + {{N{1'b0}}, wen_c};
    fill_next = wbin_next - rbin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q         <= '0;
      wcount_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wovf_q         <= 1'b0;
    end else begin
      wbin_q         <= wbin_next;
      wcount_q       <= fill_next;
      wfull_q        <= (fill_next == DEPTH);
      walmost_full_q <= (fill_next >= AF_LEVEL);
      wovf_q         <= wovf_q | (wif.winc & wfull_q);
    end
  end

  assign wif.wen          = wen_c;
  assign wif.waddr        = wbin_q[N-1:0];
  assign wif.wbin         = wbin_q;
  assign wif.wfull        = wfull_q;
  assign wif.walmost_full = walmost_full_q;
  assign wif.wcount       = wcount_q;
  assign wif.wovf         = wovf_q;

endmodule

// File: doc/fifo_wptr_full_ctrl.md
Name: fifo_wptr_full_ctrl

Overview:
- Write-side pointer and full-flag controller for the async FIFO. Runs in the write clock domain.
- Keeps the (N+1)-bit binary write pointer. This pointer feeds the downstream bin_to_gray_converter, whose Gray output is synchronised into the read domain.
- Takes the 2-flop-synchronised Gray read pointer, converts it to binary internally, and produces wfull, almost-full, fill count and a sticky overflow flag.

Parameters:
- N, 4, address width; FIFO depth = 2^N; pointers are N+1 bits.
- AF_THRESH, 12, walmost_full asserts when fill count is at or above this value; legal range 1..2^N.

Ports:
- clk  input  1  write-domain clock.
- rst  input  1  synchronous, active-high reset.
- winc  input  1  write request from the producer.
- wq2_rptr  input  N+1  Gray read pointer, already synchronised into clk.
- wen  output  1  write accepted this cycle (combinational) = winc & ~wfull; drives the RAM write enable.
- waddr  output  N  RAM write address = wbin[N-1:0].
- wbin  output  N+1  registered binary write pointer; feeds bin_to_gray_converter.bin.
- wfull  output  1  FIFO full, registered.
- walmost_full  output  1  fill count >= AF_THRESH, registered.
- wcount  output  N+1  write-side fill count, range 0..2^N, registered.
- wovf  output  1  sticky overflow: a write was attempted while full.

Behaviour:
- Reset (rst=1 at a clk edge) clears everything: wbin=0, wfull=0, walmost_full=0, wcount=0, wovf=0. Reset overrides any winc in the same cycle; a write in progress is dropped. wen reads 0 while rst=1.
- Gray-to-binary conversion (combinational):
  - rbin[N] = wq2_rptr[N];
  - rbin[i] = rbin[i+1] ^ wq2_rptr[i], for i = N-1 down to 0.
- Next-state values:
  - wbin_next = wbin + wen, modulo 2^(N+1). Wrap from 2^(N+1)-1 to 0 is natural; there is no saturation.
  - fill_next = (wbin_next - rbin), modulo 2^(N+1).
- Registered updates at each clk edge (rst=0):
  - wbin <= wbin_next;
  - wcount <= fill_next;
  - wfull <= (fill_next == 2^N), equivalently MSBs differ and the lower N bits are equal;
  - walmost_full <= (fill_next >= AF_THRESH);
  - wovf <= wovf | (winc & wfull).
- Flag timing:
  - All flags reflect the state after this cycle's write, so wfull is valid the cycle after the write that fills the FIFO.
  - No write is ever accepted while wfull=1, and no extra cycle of latency is allowed.
- Write handshake:
  - A write occurs on every edge where wen=1.
  - winc held high while full is ignored: no pointer move, wovf sets.
  - The producer does not need to drop winc.
- Conservative full:
  - The read pointer arrives 2+ cycles late, so wfull and wcount over-estimate occupancy, never under-estimate.
  - wfull deasserts on the first edge after wq2_rptr shows progress, provided no write refills it in that same cycle.
- Simultaneous write and rptr advance in one cycle: fill_next accounts for both, so the count stays constant.
- wq2_rptr legality:
  - It changes by at most one Gray step per cycle.
  - It never leads wbin; a fill above 2^N is illegal input.
  - The block does not check for it; the verification engineer asserts it in the bench.
- Read-side empty and counters are out of scope for this block.

Test Plan:
- Reset: hold winc=1 with rst=1 for 3 cycles -> wen=0 and all outputs 0; after release, the first write gives waddr=0, then wbin=1 and wcount=1.
- Fill to full: wq2_rptr=0, winc=1 for 16 cycles -> waddr steps 0..15; walmost_full=1 after the 12th write; wfull=1 after the 16th (wbin=5'b10000, wcount=16); a 17th winc gives wen=0, wbin unchanged, wovf=1.
- Release from full: from full, set wq2_rptr=gray(1)=5'b00001 with winc=0 -> next edge wfull=0, wcount=15; with winc=1 that same cycle, wen=0 and the next cycle wen=1 refills, so wfull=1 again.
- Simultaneous: wbin=5 and rbin=2 (wq2_rptr=5'b00011); winc=1 while wq2_rptr steps to gray(3)=5'b00010 -> wcount stays 3, wbin=6.
- Pointer wrap: stream writes with rptr tracking 3 behind through 31->0 -> wbin wraps to 0, waddr wraps 15->0, wcount constant at 3, wfull never asserts.
- Overflow sticky: trigger wovf, then drain to empty -> wovf stays 1 until rst pulses, then reads 0.
